// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if: pipeline stage fields in, stall/flush/forward controls out.
interface hazard_sequencer_if;
    logic [2:0] id_opcode;
    logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ack;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, pc_src;
    logic [1:0] forward_a, forward_b, state;
    logic mem_timeout_err;
    logic [15:0] stall_cnt, flush_cnt;
    modport master (
        output id_opcode, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
        output ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ack,
        input pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, pc_src,
        input forward_a, forward_b, state, mem_timeout_err, stall_cnt, flush_cnt
    );
    modport slave (
        input id_opcode, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
        input ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ack,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, pc_src,
        output forward_a, forward_b, state, mem_timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush/forwarding control with a memory-wait watchdog.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_sequencer (
    input logic Clock_in,
    input logic Reset_in,
    hazard_sequencer_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, LU_STALL = 2'b01, BR_FLUSH = 2'b10, MEM_WAIT = 2'b11} state_t;
    state_t state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic err_q, err_d;
    logic rs2_used, load_use, freeze, branch, stall_lu;
    assign rs2_used = bus.id_opcode inside {3'b000, 3'b011, 3'b100};
    assign load_use = bus.ex_mem_read && bus.ex_rd != 4'd0 &&
                      (bus.ex_rd == bus.id_rs1 || (rs2_used && bus.ex_rd == bus.id_rs2));
    always_comb begin
        state_d = RUN;
        wd_d = wd_q;
        err_d = err_q;
        freeze = 1'b0;
        branch = 1'b0;
        stall_lu = 1'b0;
        if (state_q == MEM_WAIT) begin
            wd_d = wd_q + 8'd1;
            if (!bus.mem_ack && wd_q == 8'hFF) err_d = 1'b1;
            else if (!bus.mem_ack) begin freeze = 1'b1; state_d = MEM_WAIT; end
        end else if (bus.mem_req && !bus.mem_ack) begin
            freeze = 1'b1;
            wd_d = 8'd0;
            state_d = MEM_WAIT;
        end else if (bus.branch_taken) begin
            branch = 1'b1;
            state_d = BR_FLUSH;
        end else if (load_use && state_q != BR_FLUSH) begin
            stall_lu = 1'b1;
            state_d = LU_STALL;
        end
    end
    always_ff @(posedge Clock_in) begin
        if (Reset_in) begin
            state_q <= RUN;
            wd_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q <= wd_d;
            err_q <= err_d;
        end
    end
    // Reset forces the no-event defaults regardless of the registered state.
    assign bus.pc_write     = Reset_in || !(freeze || stall_lu);
    assign bus.if_id_write  = Reset_in || !(freeze || stall_lu);
    assign bus.id_ex_write  = Reset_in || !freeze;
    assign bus.ex_mem_write = Reset_in || !freeze;
    assign bus.if_id_flush  = !Reset_in && branch;
    assign bus.id_ex_flush  = !Reset_in && (branch || stall_lu);
    assign bus.pc_src       = !Reset_in && branch;
    assign bus.forward_a = Reset_in ? 2'b00 :
        (bus.mem_reg_write && bus.mem_rd != 4'd0 && bus.mem_rd == bus.ex_rs1) ? 2'b10 :
        (bus.wb_reg_write && bus.wb_rd != 4'd0 && bus.wb_rd == bus.ex_rs1) ? 2'b01 : 2'b00;
    assign bus.forward_b = Reset_in ? 2'b00 :
        (bus.mem_reg_write && bus.mem_rd != 4'd0 && bus.mem_rd == bus.ex_rs2) ? 2'b10 :
        (bus.wb_reg_write && bus.wb_rd != 4'd0 && bus.wb_rd == bus.ex_rs2) ? 2'b01 : 2'b00;
    assign bus.state = state_q;
    assign bus.mem_timeout_err = err_q;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    always_comb begin
        stall_cnt_d = (!bus.pc_write && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = (bus.id_ex_flush && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end
    always_ff @(posedge Clock_in) begin
        if (Reset_in) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = 16'd0;
    assign bus.flush_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed and randomized checks against a rule-level reference model.
module tb_hazard_sequencer;
    logic Clock_in = 1'b0;
    logic Reset_in = 1'b1;
    hazard_sequencer_if hif();
    hazard_sequencer dut (.Clock_in(Clock_in), .Reset_in(Reset_in), .bus(hif.slave));
    always #5 Clock_in = ~Clock_in;

    localparam int EV_NONE = 0, EV_FREEZE = 1, EV_TIMEOUT = 2, EV_BRANCH = 3, EV_LU = 4;
    int checks = 0, failures = 0;
    int m_state = 0, m_wd = 0, m_sc = 0, m_fc = 0;
    bit m_err = 0;
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    function automatic bit lu_hazard();
        bit uses_rs2 = hif.id_opcode == 3'd0 || hif.id_opcode == 3'd3 || hif.id_opcode == 3'd4;
        return hif.ex_mem_read && hif.ex_rd != 0 &&
               (hif.ex_rd == hif.id_rs1 || (uses_rs2 && hif.ex_rd == hif.id_rs2));
    endfunction

    // Which rule fires this cycle, given model state (0 RUN,1 LU,2 BR,3 WAIT) and inputs.
    function automatic int event_now();
        if (m_state == 3) return hif.mem_ack ? EV_NONE : (m_wd == 255 ? EV_TIMEOUT : EV_FREEZE);
        if (hif.mem_req && !hif.mem_ack) return EV_FREEZE;
        if (hif.branch_taken) return EV_BRANCH;
        if (m_state != 2 && lu_hazard()) return EV_LU;
        return EV_NONE;
    endfunction

    function automatic logic [1:0] fwd(input logic [3:0] rs);
        if (Reset_in) return 2'b00;
        if (hif.mem_reg_write && hif.mem_rd != 0 && hif.mem_rd == rs) return 2'b10;
        if (hif.wb_reg_write && hif.wb_rd != 0 && hif.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] exp_vec();
        int ev = Reset_in ? EV_NONE : event_now();
        logic [6:0] ctl;
        logic [1:0] st = m_state[1:0];
        ctl = ev == EV_FREEZE ? 7'b0000000 : ev == EV_BRANCH ? 7'b1111111 :
              ev == EV_LU ? 7'b0011010 : 7'b1111000;
        return {ctl, fwd(hif.ex_rs1), fwd(hif.ex_rs2), st, m_err};
    endfunction

    function automatic logic [13:0] act_vec();
        return {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write,
                hif.if_id_flush, hif.id_ex_flush, hif.pc_src,
                hif.forward_a, hif.forward_b, hif.state, hif.mem_timeout_err};
    endfunction

    task automatic tick();
        int ev = Reset_in ? EV_NONE : event_now();
        bit rst = Reset_in;
        @(posedge Clock_in);
        if (rst) begin
            m_state = 0; m_wd = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (PERF == 1 && (ev == EV_FREEZE || ev == EV_LU) && m_sc < 65535) m_sc++;
            if (PERF == 1 && (ev == EV_BRANCH || ev == EV_LU) && m_fc < 65535) m_fc++;
            m_wd = (m_state == 3) ? (m_wd + 1) % 256 : (ev == EV_FREEZE ? 0 : m_wd);
            if (ev == EV_TIMEOUT) m_err = 1;
            m_state = ev == EV_FREEZE ? 3 : ev == EV_BRANCH ? 2 : ev == EV_LU ? 1 : 0;
        end
        #1;
    endtask

    task automatic idle();
        hif.id_opcode = 0; hif.id_rs1 = 0; hif.id_rs2 = 0; hif.ex_rs1 = 0; hif.ex_rs2 = 0;
        hif.ex_rd = 0; hif.mem_rd = 0; hif.wb_rd = 0; hif.ex_mem_read = 0; hif.mem_reg_write = 0;
        hif.wb_reg_write = 0; hif.branch_taken = 0; hif.mem_req = 0; hif.mem_ack = 0;
    endtask

    task automatic test_reset();
        idle(); Reset_in = 1;
        tick(); tick();
        hif.mem_req = 1; hif.branch_taken = 1; hif.ex_rs1 = 5; hif.mem_rd = 5; hif.mem_reg_write = 1;
        @(negedge Clock_in);
        checks++;
        if (act_vec() !== 14'b1111000_00_00_00_0) begin
            failures++; $display("FAIL reset_outputs: got %b want %b", act_vec(), 14'b1111000_00_00_00_0);
        end
        checks++;
        if ({hif.stall_cnt, hif.flush_cnt} !== 32'd0) begin
            failures++; $display("FAIL reset_counters: got %h want 0", {hif.stall_cnt, hif.flush_cnt});
        end
        tick(); Reset_in = 0; idle();
    endtask

    task automatic test_load_use();
        hif.ex_mem_read = 1; hif.ex_rd = 3; hif.id_opcode = 0; hif.id_rs1 = 9; hif.id_rs2 = 3;
        @(negedge Clock_in);
        checks++;
        if ({hif.pc_write, hif.if_id_write, hif.id_ex_flush} !== 3'b001) begin
            failures++; $display("FAIL lu_detect: got %b want 001", {hif.pc_write, hif.if_id_write, hif.id_ex_flush});
        end
        checks++;
        if (act_vec() !== exp_vec()) begin failures++; $display("FAIL lu_vec: got %b want %b", act_vec(), exp_vec()); end
        tick(); idle();
        @(negedge Clock_in);
        checks++;
        if (hif.state !== 2'b01) begin failures++; $display("FAIL lu_state: got %b want 01", hif.state); end
        tick();
        @(negedge Clock_in);
        checks++;
        if (hif.state !== 2'b00) begin failures++; $display("FAIL lu_return: got %b want 00", hif.state); end
        hif.ex_mem_read = 1; hif.ex_rd = 3; hif.id_opcode = 3'd1; hif.id_rs1 = 9; hif.id_rs2 = 3;
        #1;
        checks++;
        if (hif.pc_write !== 1'b1) begin failures++; $display("FAIL lu_rs2_unused: got %b want 1", hif.pc_write); end
        tick(); idle();
    endtask

    task automatic test_branch();
        hif.branch_taken = 1;
        @(negedge Clock_in);
        checks++;
        if ({hif.pc_src, hif.if_id_flush, hif.id_ex_flush, hif.pc_write} !== 4'b1111) begin
            failures++; $display("FAIL br_outputs: got %b want 1111", {hif.pc_src, hif.if_id_flush, hif.id_ex_flush, hif.pc_write});
        end
        tick(); idle();
        hif.ex_mem_read = 1; hif.ex_rd = 4; hif.id_rs1 = 4;
        @(negedge Clock_in);
        checks++;
        if ({hif.state, hif.pc_write, hif.id_ex_flush} !== 4'b1010) begin
            failures++; $display("FAIL br_suppress_lu: got %b want 1010", {hif.state, hif.pc_write, hif.id_ex_flush});
        end
        tick(); idle();
        @(negedge Clock_in);
        checks++;
        if (hif.state !== 2'b00) begin failures++; $display("FAIL br_return: got %b want 00", hif.state); end
        tick();
    endtask

    task automatic test_forwarding();
        logic [3:0] rs [5] = '{5, 5, 0, 5, 7};
        logic [3:0] mr [5] = '{5, 5, 0, 6, 7};
        logic [3:0] wr [5] = '{5, 5, 0, 5, 2};
        logic       mw [5] = '{1, 0, 1, 1, 1};
        logic       ww [5] = '{1, 1, 1, 1, 0};
        logic [1:0] ex [5] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 5; i++) begin
            idle();
            hif.ex_rs1 = rs[i]; hif.ex_rs2 = rs[i]; hif.mem_rd = mr[i]; hif.wb_rd = wr[i];
            hif.mem_reg_write = mw[i]; hif.wb_reg_write = ww[i];
            @(negedge Clock_in);
            checks++;
            if ({hif.forward_a, hif.forward_b} !== {ex[i], ex[i]}) begin
                failures++; $display("FAIL fwd_case%0d: got %b want %b", i, {hif.forward_a, hif.forward_b}, {ex[i], ex[i]});
            end
            tick();
        end
        idle();
    endtask

    task automatic test_mem_stall();
        Reset_in = 1; tick(); Reset_in = 0;
        idle(); hif.mem_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock_in);
            checks++;
            if ({hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write, hif.id_ex_flush} !== 5'b0) begin
                failures++; $display("FAIL mem_freeze%0d: got %b want 00000", i,
                    {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write, hif.id_ex_flush});
            end
            tick();
        end
        hif.mem_ack = 1;
        @(negedge Clock_in);
        checks++;
        if ({hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write, hif.state} !== 6'b1111_11) begin
            failures++; $display("FAIL mem_release: got %b want 111111", {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write, hif.state});
        end
        tick(); idle();
        @(negedge Clock_in);
        checks++;
        if ({hif.state, hif.stall_cnt} !== {2'b00, 16'(PERF * 5)}) begin
            failures++; $display("FAIL mem_after: got state=%b stall_cnt=%0d want 00/%0d", hif.state, hif.stall_cnt, PERF * 5);
        end
        tick();
    endtask

    task automatic test_timeout();
        idle(); hif.mem_req = 1;
        for (int i = 0; i < 256; i++) begin
            @(negedge Clock_in);
            checks++;
            if ({hif.pc_write, hif.ex_mem_write, hif.mem_timeout_err} !== 3'b000) begin
                failures++; $display("FAIL wd_frozen%0d: got %b want 000", i, {hif.pc_write, hif.ex_mem_write, hif.mem_timeout_err});
            end
            tick();
        end
        hif.mem_req = 0;
        @(negedge Clock_in);
        checks++;
        if ({hif.pc_write, hif.ex_mem_write, hif.state} !== 4'b1111) begin
            failures++; $display("FAIL wd_release: got %b want 1111", {hif.pc_write, hif.ex_mem_write, hif.state});
        end
        tick(); tick(); tick();
        @(negedge Clock_in);
        checks++;
        if ({hif.state, hif.mem_timeout_err} !== 3'b001) begin
            failures++; $display("FAIL wd_sticky: got %b want 001", {hif.state, hif.mem_timeout_err});
        end
        Reset_in = 1; tick(); Reset_in = 0;
        @(negedge Clock_in);
        checks++;
        if (hif.mem_timeout_err !== 1'b0) begin failures++; $display("FAIL wd_clear: got %b want 0", hif.mem_timeout_err); end
        tick();
    endtask

    task automatic test_reset_mem_wait();
        idle(); hif.mem_req = 1;
        tick(); tick();
        Reset_in = 1; hif.ex_rs1 = 5; hif.mem_rd = 5; hif.mem_reg_write = 1;
        @(negedge Clock_in);
        checks++;
        if ({hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write, hif.forward_a, hif.state} !== 8'b1111_00_11) begin
            failures++; $display("FAIL rst_in_wait: got %b want 11110011",
                {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write, hif.forward_a, hif.state});
        end
        tick(); Reset_in = 0; idle();
        @(negedge Clock_in);
        checks++;
        if ({hif.state, hif.pc_write, hif.ex_mem_write, hif.stall_cnt, hif.flush_cnt} !== {4'b0011, 32'd0}) begin
            failures++; $display("FAIL rst_after_wait: got state=%b pcw=%b sc=%0d fc=%0d want 00/1/0/0",
                hif.state, hif.pc_write, hif.stall_cnt, hif.flush_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            Reset_in = $urandom_range(0, 199) == 0;
            hif.id_opcode = 3'($urandom_range(0, 7));
            hif.id_rs1 = 4'($urandom_range(0, 3)); hif.id_rs2 = 4'($urandom_range(0, 3));
            hif.ex_rs1 = 4'($urandom_range(0, 3)); hif.ex_rs2 = 4'($urandom_range(0, 3));
            hif.ex_rd = 4'($urandom_range(0, 3)); hif.mem_rd = 4'($urandom_range(0, 3));
            hif.wb_rd = 4'($urandom_range(0, 3));
            hif.ex_mem_read = 1'($urandom_range(0, 1));
            hif.mem_reg_write = 1'($urandom_range(0, 1)); hif.wb_reg_write = 1'($urandom_range(0, 1));
            hif.branch_taken = m_state != 3 && $urandom_range(0, 5) == 0;
            hif.mem_req = $urandom_range(0, 7) == 0;
            hif.mem_ack = $urandom_range(0, 2) == 0;
            @(negedge Clock_in);
            checks++;
            if (act_vec() !== exp_vec()) begin failures++; $display("FAIL rand_vec%0d: got %b want %b", i, act_vec(), exp_vec()); end
            checks++;
            if ({hif.stall_cnt, hif.flush_cnt} !== {m_sc[15:0], m_fc[15:0]}) begin
                failures++; $display("FAIL rand_cnt%0d: got %0d/%0d want %0d/%0d", i, hif.stall_cnt, hif.flush_cnt, m_sc, m_fc);
            end
            tick();
        end
        Reset_in = 0; idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_forwarding();
        test_mem_stall();
        test_timeout();
        test_reset_mem_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Clock_in  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset_in  in  1  synchronous reset, active-high.
REQ-003 id_opcode  in  3  opcode of instruction in ID.
REQ-004 id_rs1, id_rs2  in  4 each  source register fields in ID.
REQ-005 ex_rs1, ex_rs2, ex_rd  in  4 each  register fields in EXE; ex_mem_read  in  1  EXE instruction is a load.
REQ-006 mem_rd  in  4; mem_reg_write  in  1  MEM-stage destination and write flag.
REQ-007 wb_rd  in  4; wb_reg_write  in  1  WB-stage destination and write flag.
REQ-008 branch_taken  in  1  branch resolved taken in EXE.
REQ-009 mem_req  in  1; mem_ack  in  1  data-memory access handshake from MEM.
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage register enables.
REQ-011 if_id_flush, id_ex_flush  out  1 each  insert bubble; pc_src  out  1  select branch target.
REQ-012 forward_a, forward_b  out  2 each  ALU operand select: 00 register file, 01 WB, 10 MEM.
REQ-013 state  out  2; mem_timeout_err  out  1  sticky watchdog flag.
REQ-014 stall_cnt, flush_cnt  out  16 each  performance counters (see Configuration).

Function
REQ-015 States: RUN=00, LU_STALL=01, BR_FLUSH=10, MEM_WAIT=11; state output equals the current state register.
REQ-016 Default outputs (no event): all write enables 1, flushes 0, pc_src 0.
REQ-017 Register 0 never participates in hazard or forwarding comparisons.
REQ-018 Priority in any non-MEM_WAIT state: memory stall > branch > load-use.
REQ-019 Memory stall: mem_req=1 and mem_ack=0 -> all four enables 0, no flush; next state MEM_WAIT.
REQ-020 MEM_WAIT: enables held 0 while mem_ack=0; cycle with mem_ack=1 -> enables 1, next RUN.
REQ-021 Watchdog: 8-bit counter cleared on MEM_WAIT entry and incremented each MEM_WAIT cycle; when it reaches 255 with mem_ack still 0, set mem_timeout_err, release enables that cycle, next RUN.
REQ-022 Branch: branch_taken=1 -> pc_src=1, if_id_flush=1, id_ex_flush=1, enables 1; next BR_FLUSH.
REQ-023 BR_FLUSH lasts exactly one cycle with load-use detection suppressed; memory stall and branch rules still apply; then RUN.
REQ-024 Load-use: ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs1 or (rs2 used and ex_rd==id_rs2)) -> pc_write=0, if_id_write=0, id_ex_flush=1; next LU_STALL.
REQ-025 rs2 is used for opcodes 000 (R-type), 011 (store), 100 (branch) only.
REQ-026 LU_STALL lasts one cycle with full REQ-018 priority, then RUN unless a higher-priority rule redirects.
REQ-027 Forwarding is combinational and independent of state: MEM match (mem_reg_write, mem_rd==ex_rsN) -> 10; else WB match -> 01; else 00.
REQ-028 Simultaneous mem stall and branch_taken: stall wins; branch is re-evaluated when the freeze releases, since EXE is held.

Reset
REQ-029 Reset_in=1 at a clock edge -> state RUN, watchdog 0, mem_timeout_err 0, counters 0.
REQ-030 While Reset_in=1, outputs are the REQ-016 defaults and forward selects are 00, including reset mid-MEM_WAIT.
REQ-031 mem_timeout_err clears only on reset.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: stall_cnt increments on every cycle with pc_write=0; flush_cnt increments on every cycle with id_ex_flush=1; both saturate at 16'hFFFF.
REQ-033 Macro HAZARD_PERF_CNT_EN undefined: stall_cnt and flush_cnt are constant 0 and no counter registers exist.

Verification
REQ-034 ex_mem_read=1, ex_rd=3, id_opcode=000, id_rs2=3 -> pc_write=0, if_id_write=0, id_ex_flush=1; next cycle state=01; cycle after, state=00.
REQ-035 branch_taken=1 -> pc_src=1 and both flushes 1 in the same cycle; state=10 for one cycle; a load-use match in that cycle produces no stall.
REQ-036 mem_req=1, mem_ack=0 for 5 cycles, then ack -> enables 0 for 5 cycles, 1 on the ack cycle, then state=00; stall_cnt=5 with macro defined.
REQ-037 mem_req=1, mem_ack never asserted -> mem_timeout_err=1 after 256 frozen cycles, then RUN; the flag stays set until Reset_in.
REQ-038 mem_rd=wb_rd=ex_rs1=5 with both write flags set -> forward_a=10; mem_rd=0=ex_rs1 -> forward_a=00.
REQ-039 Reset_in asserted during MEM_WAIT -> next cycle state=00, enables 1, counters 0.
